mem_arbiter: RTL

- Shares one slow memory port (128-bit line, 28-bit line address) between the I-cache and D-cache miss/writeback interfaces inside CHIP.
- Lets the unified-memory and L2 configurations drop the second slow_memory instance.
- Registered two-requester arbiter with a grant FSM, request forwarding, ready steering and grant statistics counters.
- Both caches keep their existing handshake: hold read/write until a ready pulse.

---
 rtl/mem_arbiter_pkg.sv | 51 +++++
 rtl/mem_arbiter_sat_counter.sv | 29 ++
 rtl/mem_arbiter.sv | 120 ++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-requester slow-memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned LINE_W  = 128;
  localparam int unsigned LADDR_W = 28;

  localparam int unsigned PRIO_RR      = 0;
  localparam int unsigned PRIO_FIXED_D = 1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SERVE_I = 2'd1;
  localparam logic [1:0] ST_SERVE_D = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    SERVE_I = ST_SERVE_I,
    SERVE_D = ST_SERVE_D
  } state_e;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_e;

  typedef struct packed {
    logic               read;
    logic               write;
    logic [LADDR_W-1:0] addr;
    logic [LINE_W-1:0]  wdata;
  } mem_req_t;

  // Arbitration decision taken in IDLE; ties go to D under fixed priority,
  // otherwise to whichever side did not own the last transaction.
  function automatic state_e pick_winner(input logic   req_i,
                                         input logic   req_d,
                                         input logic   fixed_d,
                                         input owner_e last_owner);
    state_e nxt;
    nxt = IDLE;
    if (req_i && req_d) begin
      if (fixed_d || (last_owner == OWNER_I)) nxt = SERVE_D;
      else                                    nxt = SERVE_I;
    end else if (req_d) begin
      nxt = SERVE_D;
    end else if (req_i) begin
      nxt = SERVE_I;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/mem_arbiter_sat_counter.sv
// Saturating up-counter used for per-side grant statistics.
module mem_arbiter_sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Hold at all-ones instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one slow memory port between the I-cache and D-cache miss interfaces;
// one transaction at a time, with a forced IDLE cycle between transactions.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned PRIORITY_MODE = PRIO_RR,
  parameter int unsigned CNT_W         = 16
) (
  input  logic               clk,
  input  logic               rst_n,

  input  logic               req_read_I,
  input  logic               req_write_I,
  input  logic [LADDR_W-1:0] req_addr_I,
  input  logic [LINE_W-1:0]  req_wdata_I,
  output logic [LINE_W-1:0]  rdata_I,
  output logic               ready_I,

  input  logic               req_read_D,
  input  logic               req_write_D,
  input  logic [LADDR_W-1:0] req_addr_D,
  input  logic [LINE_W-1:0]  req_wdata_D,
  output logic [LINE_W-1:0]  rdata_D,
  output logic               ready_D,

  output logic               mem_read,
  output logic               mem_write,
  output logic [LADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0]  mem_wdata,
  input  logic [LINE_W-1:0]  mem_rdata,
  input  logic               mem_ready,

  output logic [CNT_W-1:0]   grant_cnt_I,
  output logic [CNT_W-1:0]   grant_cnt_D
);

  localparam logic FIXED_D = (PRIORITY_MODE == PRIO_FIXED_D);

  state_e   state_q, state_d;
  owner_e   last_owner_q, last_owner_d;
  mem_req_t req_i_c, req_d_c, fwd_c;
  logic     inc_i_c, inc_d_c;

  assign req_i_c = {req_read_I, req_write_I, req_addr_I, req_wdata_I};
  assign req_d_c = {req_read_D, req_write_D, req_addr_D, req_wdata_D};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_owner_q <= OWNER_I;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
    end
  end

  // The owner's request is forwarded unchanged while it is served; the other
  // side simply keeps holding its request until the next IDLE evaluation.
  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    fwd_c        = '0;
    ready_I      = 1'b0;
    ready_D      = 1'b0;
    inc_i_c      = 1'b0;
    inc_d_c      = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = pick_winner(req_i_c.read | req_i_c.write,
                              req_d_c.read | req_d_c.write,
                              FIXED_D, last_owner_q);
      end
      SERVE_I: begin
        fwd_c   = req_i_c;
        ready_I = mem_ready;
        if (mem_ready) begin
          state_d      = IDLE;
          last_owner_d = OWNER_I;
          inc_i_c      = 1'b1;
        end
      end
      SERVE_D: begin
        fwd_c   = req_d_c;
        ready_D = mem_ready;
        if (mem_ready) begin
          state_d      = IDLE;
          last_owner_d = OWNER_D;
          inc_d_c      = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mem_read  = fwd_c.read;
  assign mem_write = fwd_c.write;
  assign mem_addr  = fwd_c.addr;
  assign mem_wdata = fwd_c.wdata;

  // Read data is broadcast; each cache qualifies it with its own ready.
  assign rdata_I = mem_rdata;
  assign rdata_D = mem_rdata;

  mem_arbiter_sat_counter #(.W(CNT_W)) u_cnt_i (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_i_c),
    .count (grant_cnt_I)
  );

  mem_arbiter_sat_counter #(.W(CNT_W)) u_cnt_d (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (inc_d_c),
    .count (grant_cnt_D)
  );

endmodule
